// File: rtl/dual_rail_value_extract.sv
// Dual-rail link receiver: synchronizes a two-phase or four-phase link, decodes the word and drives a valid/ready output.
// Optional protocol-error checking is built only when DUAL_RAIL_ERR_CHECK_EN is defined.
module dual_rail_value_extract #(
  parameter     ENC   = "TP",
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0][1:0] in,
  output logic                  ack,
  output logic [WIDTH-1:0]      data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  err
);

  localparam logic IS_FP = (ENC == "FP") ? 1'b1 : 1'b0;

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RTZ  = 2'd2;

  logic [WIDTH-1:0][1:0] r_sync1;
  logic [WIDTH-1:0][1:0] r_sync2;
  logic [WIDTH-1:0][1:0] r_ref;
  logic [1:0]            r_state;
  logic                  r_valid;
  logic                  r_ack;
  logic [WIDTH-1:0]      r_data;

  logic [WIDTH-1:0][1:0] w_cmp;
  logic [WIDTH-1:0]      w_bit_done;
  logic [WIDTH-1:0]      w_bit_val;
  logic                  w_word_done;
  logic                  w_rails_zero;

  // Two-flop synchronizer on every rail; nothing else looks at the raw link.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

  // In two-phase mode a rail "fires" when it differs from its reference copy.
  assign w_cmp = IS_FP ? r_sync2 : (r_sync2 ^ r_ref);

  // Per-bit completion: exactly one rail fired; the value comes from rail [1].
  always_comb begin
    w_bit_done = '0;
    w_bit_val  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bit_done[i] = w_cmp[i][1] ^ w_cmp[i][0];
      w_bit_val[i]  = w_cmp[i][1];
    end
  end

  assign w_word_done  = &w_bit_done;
  assign w_rails_zero = (r_sync2 == '0);

  // Handshake state machine: capture a complete word, hold it, acknowledge the sender.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_ref   <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_word_done) begin
            r_state <= S_HOLD;
            r_valid <= 1'b1;
            r_data  <= w_bit_val;
          end
        end
        S_HOLD: begin
          if (ready) begin
            r_valid <= 1'b0;
            if (IS_FP) begin
              r_ack   <= 1'b1;
              r_state <= S_RTZ;
            end else begin
              r_ack   <= ~r_ack;
              r_ref   <= r_sync2;
              r_state <= S_WAIT;
            end
          end
        end
        S_RTZ: begin
          if (w_rails_zero) begin
            r_ack   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        default: begin
          r_state <= S_WAIT;
          r_valid <= 1'b0;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign ack   = r_ack;
  assign data  = r_data;
  assign valid = r_valid;

`ifdef DUAL_RAIL_ERR_CHECK_EN
  logic [WIDTH-1:0]      w_bit_bad;
  logic [WIDTH-1:0][1:0] r_prev;
  logic                  r_err;

  // A bit with both rails fired is illegal in either encoding.
  always_comb begin
    w_bit_bad = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bit_bad[i] = w_cmp[i][1] & w_cmp[i][0];
    end
  end

  // Sticky error: illegal rail pair, or any rail moving while a word is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_err  <= 1'b0;
    end else begin
      r_prev <= r_sync2;
      if ((|w_bit_bad) || ((r_state == S_HOLD) && (r_sync2 != r_prev))) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dual_rail_value_extract.sv
// Self-checking bench: one four-phase and one two-phase receiver (WIDTH = 4), directed cases plus randomized traffic.
module tb_dual_rail_value_extract;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0][1:0] fp_in, tp_in;
  logic            fp_ready, tp_ready;
  logic            fp_ack, tp_ack, fp_valid, tp_valid, fp_err, tp_err;
  logic [3:0]      fp_data, tp_data;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [3:0] exp_q[$];
  bit         send_done;

`ifdef DUAL_RAIL_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  dual_rail_value_extract #(.ENC("FP"), .WIDTH(4)) u_fp (
    .clk(clk), .rst(rst), .in(fp_in), .ack(fp_ack), .data(fp_data),
    .valid(fp_valid), .ready(fp_ready), .err(fp_err)
  );

  dual_rail_value_extract #(.ENC("TP"), .WIDTH(4)) u_tp (
    .clk(clk), .rst(rst), .in(tp_in), .ack(tp_ack), .data(tp_data),
    .valid(tp_valid), .ready(tp_ready), .err(tp_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one bit of a word onto the link using the encoding's rules.
  task automatic drive_bit(input bit fp, input int b, input logic v);
    if (fp) fp_in[b] = v ? 2'b10 : 2'b01;
    else    tp_in[b] = tp_in[b] ^ (v ? 2'b10 : 2'b01);
  endtask

  task automatic send_all(input bit fp, input logic [3:0] w);
    for (int b = 0; b < 4; b++) drive_bit(fp, b, w[b]);
  endtask

  task automatic wait_valid(input bit fp, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fp ? fp_valid : tp_valid) && n < 40);
  endtask

  task automatic wait_ack(input bit fp, input logic lvl, input int max, input string tag);
    int n;
    n = 0;
    while ((fp ? fp_ack : tp_ack) !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, fp ? fp_ack : tp_ack, lvl);
  endtask

  // Sender model: bits arrive in random order, then the protocol's acknowledge is awaited.
  task automatic random_send(input bit fp, input logic [3:0] w);
    logic [3:0] pend;
    int         b;
    logic       a0;
    a0 = tp_ack;
    exp_q.push_back(w);
    pend = 4'hF;
    while (pend != 4'h0) begin
      b = $urandom_range(3, 0);
      if (pend[b]) begin
        drive_bit(fp, b, w[b]);
        pend[b] = 1'b0;
      end
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end
    if (fp) begin
      wait_ack(1'b1, 1'b1, 400, "rnd_fp_ack_hi");
      pend = 4'hF;
      while (pend != 4'h0) begin
        b = $urandom_range(3, 0);
        if (pend[b]) begin
          fp_in[b] = 2'b00;
          pend[b]  = 1'b0;
        end
        if ($urandom_range(1, 0) == 1) @(negedge clk);
      end
      wait_ack(1'b1, 1'b0, 100, "rnd_fp_ack_lo");
    end else begin
      wait_ack(1'b0, ~a0, 400, "rnd_tp_ack_tgl");
    end
  endtask

  // Consumer model with random ready; words must appear in send order.
  task automatic monitor(input bit fp);
    logic       v, r, pv, pa;
    logic [3:0] d, held;
    pv = 1'b0; pa = 1'b0; held = 4'h0;
    while (!send_done) begin
      @(negedge clk);
      v = fp ? fp_valid : tp_valid;
      d = fp ? fp_data : tp_data;
      if (pa) check_eq("rnd_gap", v, 1'b0);
      if (v && !pv) begin
        if (exp_q.size() == 0) check_eq("rnd_spurious", v, 1'b0);
        else begin
          held = exp_q.pop_front();
          check_eq("rnd_data", d, held);
        end
      end else if (v) begin
        check_eq("rnd_hold_data", d, held);
      end
      r = ($urandom_range(2, 0) != 0);
      if (fp) fp_ready = r; else tp_ready = r;
      pa = v & r;
      pv = v;
    end
  endtask

  task automatic random_phase(input bit fp, input int nwords);
    send_done = 1'b0;
    fork
      begin
        for (int k = 0; k < nwords; k++) random_send(fp, 4'($urandom_range(15, 0)));
        send_done = 1'b1;
      end
      monitor(fp);
    join
    if (fp) fp_ready = 1'b1; else tp_ready = 1'b1;
    check_eq("rnd_drain", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    rst = 1'b1; fp_in = '0; tp_in = '0; fp_ready = 1'b1; tp_ready = 1'b1; send_done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_fp", {fp_valid, fp_ack, fp_err, fp_data}, 7'h00);
    check_eq("rst_tp", {tp_valid, tp_ack, tp_err, tp_data}, 7'h00);
    rst = 1'b0;
    @(negedge clk);

    // Four-phase word 0xA with ready high.
    send_all(1'b1, 4'hA);
    wait_valid(1'b1, n);
    check_eq("fp_lat_A", n, 3);
    check_eq("fp_data_A", fp_data, 4'hA);
    @(negedge clk);
    check_eq("fp_vld_pulse", fp_valid, 1'b0);
    check_eq("fp_ack_rise", fp_ack, 1'b1);
    fp_in = '0;
    wait_ack(1'b1, 1'b0, 20, "fp_ack_fall");
    cnt = 0;
    repeat (10) begin @(negedge clk); if (fp_valid) cnt++; end
    check_eq("fp_no_second", cnt, 0);

    // Partial word must not produce output; last bit completes it.
    fp_in[0] = 2'b01; fp_in[1] = 2'b10; fp_in[2] = 2'b10;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (fp_valid) cnt++; end
    check_eq("fp_partial", cnt, 0);
    fp_in[3] = 2'b10;
    wait_valid(1'b1, n);
    check_eq("fp_lat_last", n, 3);
    check_eq("fp_data_E", fp_data, 4'hE);
    @(negedge clk);
    check_eq("fp_ack_E", fp_ack, 1'b1);
    fp_in = '0;
    wait_ack(1'b1, 1'b0, 20, "fp_ack_fall_E");

    // Backpressure: ready low holds valid and data, ack stays low.
    fp_ready = 1'b0;
    send_all(1'b1, 4'h3);
    wait_valid(1'b1, n);
    check_eq("fp_lat_bp", n, 3);
    repeat (10) begin
      @(negedge clk);
      check_eq("bp_valid", fp_valid, 1'b1);
      check_eq("bp_data", fp_data, 4'h3);
      check_eq("bp_ack", fp_ack, 1'b0);
    end
    fp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_ack_rise", fp_ack, 1'b1);
    check_eq("bp_valid_drop", fp_valid, 1'b0);
    fp_in = '0;
    wait_ack(1'b1, 1'b0, 20, "bp_ack_fall");

    // Two-phase: two transfers of 0x5, ack toggles up then down.
    send_all(1'b0, 4'h5);
    wait_valid(1'b0, n);
    check_eq("tp_lat_1", n, 3);
    check_eq("tp_data_1", tp_data, 4'h5);
    @(negedge clk);
    check_eq("tp_ack_1", tp_ack, 1'b1);
    check_eq("tp_valid_drop", tp_valid, 1'b0);
    send_all(1'b0, 4'h5);
    wait_valid(1'b0, n);
    check_eq("tp_lat_2", n, 3);
    check_eq("tp_data_2", tp_data, 4'h5);
    @(negedge clk);
    check_eq("tp_ack_2", tp_ack, 1'b0);

    // Both rails of bit 0 high: sticky error when checking is built.
    fp_in[0] = 2'b11;
    repeat (5) @(negedge clk);
    check_eq("err_set", fp_err, EXP_ERR);
    check_eq("err_no_word", fp_valid, 1'b0);
    fp_in = '0;
    repeat (5) @(negedge clk);
    check_eq("err_sticky", fp_err, EXP_ERR);
    check_eq("tp_err_clean", tp_err, 1'b0);
    rst = 1'b1; fp_in = '0; tp_in = '0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("err_clear", fp_err, 1'b0);

    // Reset while holding a word discards it.
    fp_ready = 1'b0;
    send_all(1'b1, 4'h9);
    wait_valid(1'b1, n);
    check_eq("hold_data_9", fp_data, 4'h9);
    rst = 1'b1; fp_in = '0; tp_in = '0;
    @(negedge clk);
    check_eq("rst_hold", {fp_valid, fp_ack, fp_data}, 6'h00);
    rst = 1'b0;
    fp_ready = 1'b1;
    send_all(1'b1, 4'h6);
    wait_valid(1'b1, n);
    check_eq("post_rst_lat", n, 3);
    check_eq("post_rst_data", fp_data, 4'h6);
    @(negedge clk);
    check_eq("rtz_ack", fp_ack, 1'b1);
    rst = 1'b1; fp_in = '0;
    @(negedge clk);
    check_eq("rst_rtz", {fp_valid, fp_ack}, 2'b00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    random_phase(1'b1, 16);
    random_phase(1'b0, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dual_rail_value_extract.md
DUAL_RAIL_VALUE_EXTRACT -- requirements
Module: dual_rail_value_extract

Interface
REQ-001 Parameter ENC, default "TP": link encoding; "TP" is two-phase (transition), "FP" is four-phase (return-to-zero).
REQ-002 Parameter WIDTH, default 1: number of dual-rail bits on the link.
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in  input  [WIDTH-1:0][1:0]  dual-rail link from the sender, asynchronous to clk; rail [1] encodes 1 and rail [0] encodes 0.
REQ-006 ack  output  1  link acknowledge to the sender.
REQ-007 data  output  [WIDTH-1:0]  decoded word.
REQ-008 valid  output  1  data holds a decoded word.
REQ-009 ready  input  1  consumer accepts data when valid && ready.
REQ-010 err  output  1  sticky protocol-error flag.

Function
REQ-011 Every rail of in SHALL pass through a two-flop synchronizer before use; no other logic SHALL sample in directly.
REQ-012 TP per-bit completion: exactly one synchronized rail differs from the stored per-rail reference register ref[WIDTH-1:0][1:0]; decoded value = 1 if rail [1] differs.
REQ-013 FP per-bit completion: exactly one synchronized rail is high; decoded value = rail [1].
REQ-014 A word is complete only when every bit is complete in the same cycle.
REQ-015 States: WAIT (awaiting complete word), HOLD (valid high), RTZ (FP only, awaiting spacer).
REQ-016 WAIT -> HOLD on the cycle after the word is detected complete; data is registered on that transition and valid = 1.
REQ-017 Latency: word stable on in at cycle N -> valid = 1 at cycle N+3.
REQ-018 data SHALL remain constant while valid = 1.
REQ-019 HOLD with ready = 1 -> valid = 0 on the next cycle, and:
- TP: ack toggles, ref loads the synchronized rails, return to WAIT.
- FP: ack = 1, go to RTZ.
REQ-020 HOLD with ready = 0: stay in HOLD, ack unchanged; this provides backpressure to the sender.
REQ-021 RTZ: when all synchronized rails are 0, ack = 0 on the next cycle and the block returns to WAIT; otherwise it stays in RTZ.
REQ-022 Valid-to-ready handshake: a new valid SHALL NOT assert in the same cycle that the previous word is accepted; the minimum gap is one WAIT cycle.
REQ-023 A partially complete word in WAIT SHALL produce no output change.
REQ-024 For WIDTH = 1, the behaviour is identical with no special case.

Reset
REQ-025 With rst = 1 at a clk edge: state = WAIT, valid = 0, data = 0, ack = 0, err = 0, ref = 0, synchronizers = 0.
REQ-026 Reset mid-operation (HOLD or RTZ) SHALL discard the word in flight.
- ack returns to 0; the sender is responsible for link re-initialisation.
REQ-027 After reset in TP, the link is assumed at all-zero rails.

Configuration
REQ-028 Macro DUAL_RAIL_ERR_CHECK_EN.
REQ-029 When defined, err sets to 1 in any of these cases, and clears only on rst:
- any bit has both rails differing from ref (TP);
- any bit has both rails high (FP);
- any rail changes while in HOLD.
REQ-030 When not defined, err is tied to 0 and no checking logic is built; the rest of the behaviour is identical.

Verification
REQ-031 FP, WIDTH = 4, ready = 1: drive rails for 4'b1010 (bits 3,1 on rail [1]; bits 2,0 on rail [0]) -> valid pulses with data = 4'hA; ack rises; after all rails are 0, ack falls; no second valid.
REQ-032 TP, WIDTH = 4: toggle rails for 4'h5, then toggle rails for 4'h5 again -> two valids, each with data = 4'h5; ack toggles 0->1->0.
REQ-033 FP, ready = 0 for 10 cycles after valid -> valid held and data stable, ack stays 0; ready = 1 -> ack rises the next cycle.
REQ-034 FP, WIDTH = 4: assert bits 0-2 only for 20 cycles -> valid stays 0; assert bit 3 -> valid = 1 exactly 3 cycles later.
REQ-035 With DUAL_RAIL_ERR_CHECK_EN defined, FP: raise both rails of bit 0 -> err = 1 and remains 1 until rst; without the macro -> err stays 0.
REQ-036 Assert rst while in HOLD -> the next cycle shows valid = 0, ack = 0, data = 0, and state WAIT.
